// File: rtl/namco_cusio_gen.sv
// namco_cusio_gen: custom I/O controller in the Namco 51XX role.
//   Decodes CPU command/data bus accesses, generates the periodic I/O NMI,
//   snapshots coin/start/player inputs once per VBLK frame, and keeps a BCD credit count.
// Optional feature macro: CUSIO_COIN_COUNTER_EN adds COINCNT[1:0] (one frame high per
//   accepted coin edge).
// Ports:
//   CL     system clock              RESET  async reset, active-high
//   VBLK   vertical blank            SYS    {service,0,coin2,coin1,4'b0}
//   START  start buttons             PLR    per player {b1,spare,left,down,right,up}
//   DSW0/1 DIP banks                 CS/WR  chip select / write strobe
//   AD     AD[4]=command, else index DI     write data
//   DO     read data (combinational) NMI0   I/O NMI request
module namco_cusio_gen #(
   parameter int unsigned PLAYERS     = 2,
   parameter int unsigned NMI_PERIOD  = 2400,
   parameter int unsigned NMI_WIDTH   = 200,
   parameter int unsigned MAX_CREDITS = 99,
   parameter int unsigned START_DELAY = 4
) (
   input  logic                   CL,
   input  logic                   RESET,
   input  logic                   VBLK,
   input  logic [7:0]             SYS,
   input  logic [PLAYERS-1:0]     START,
   input  logic [6*PLAYERS-1:0]   PLR,
   input  logic [7:0]             DSW0,
   input  logic [7:0]             DSW1,
   input  logic                   CS,
   input  logic                   WR,
   input  logic [4:0]             AD,
   input  logic [7:0]             DI,
   output logic [7:0]             DO,
   output logic                   NMI0
`ifdef CUSIO_COIN_COUNTER_EN
   ,output logic [1:0]            COINCNT
`endif
);

   localparam int          NP       = int'(PLAYERS);
   localparam int unsigned CNT_W    = $clog2(NMI_PERIOD + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NMI_PERIOD);
   localparam logic [CNT_W-1:0] PULSE_AT = CNT_W'(NMI_PERIOD - NMI_WIDTH);
   localparam logic [7:0]  MAX_C    = 8'(MAX_CREDITS);
   localparam logic [4:0]  NP5      = 5'(PLAYERS);

   function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [3:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {5'd0, b};
      return (s > {1'b0, MAX_C}) ? MAX_C : s[7:0];
   endfunction

   // Shift-and-add-3 binary to BCD; credits never exceed 99 so two digits suffice.
   function automatic logic [7:0] to_bcd(input logic [7:0] bin);
      logic [11:0] bcd;
      bcd = '0;
      for (int i = 7; i >= 0; i--) begin
         if (bcd[3:0] >= 4'd5)  bcd[3:0]  = bcd[3:0] + 4'd3;
         if (bcd[7:4] >= 4'd5)  bcd[7:4]  = bcd[7:4] + 4'd3;
         if (bcd[11:8] >= 4'd5) bcd[11:8] = bcd[11:8] + 4'd3;
         bcd = {bcd[10:0], bin[i]};
      end
      return bcd[7:0];
   endfunction

   // Direction code, priority up > right > down > left.
   function automatic logic [3:0] dir_code(input logic [3:0] d);
      if (d[0])      return 4'd0;
      else if (d[1]) return 4'd2;
      else if (d[2]) return 4'd4;
      else if (d[3]) return 4'd6;
      else           return 4'd8;
   endfunction

   logic [CNT_W-1:0] nmi_cnt_q;
   logic [7:0]       command_q;
   logic             mode_sw_q, nmi_en_q, credit_at_q;
   logic [1:0][3:0]  stg_coins_q, stg_cred_q, cfg_coins_q, cfg_cred_q;
   logic             vblk_q, tick;
   logic             svc_q;
   logic [1:0]       coin_held_q, coin_edge_q, coin_edge_now;
   logic [PLAYERS-1:0] start_held_q, start_edge_now, start_dly, b1_edge_q, b1_now, b1_held;
   logic [START_DELAY-1:0][PLAYERS-1:0] start_pipe_q;
   logic [6*PLAYERS-1:0] plr_q;
   logic [7:0]       credits_q, credits_d;
   logic [1:0][3:0]  coin_cnt_q, coin_cnt_d;
   logic [1:0]       coin_ok;
   logic             cmd_wr, data_wr;
   logic [3:0]       start_dly4;
   logic [5:0]       rd_pl;
   logic             rd_edge, idx_in, unused_spare;

   assign cmd_wr         = CS & WR & AD[4];
   assign data_wr        = CS & WR & ~AD[4];
   assign tick           = VBLK & ~vblk_q;
   assign coin_edge_now  = {SYS[5], SYS[4]} & ~coin_held_q;
   assign start_edge_now = START & ~start_held_q;
   assign start_dly      = start_pipe_q[START_DELAY-1];
   assign start_dly4     = 4'(start_dly);
   assign NMI0           = nmi_en_q & (nmi_cnt_q >= PULSE_AT);

   always_comb begin
      b1_now       = '0;
      b1_held      = '0;
      unused_spare = 1'b0;
      for (int p = 0; p < NP; p++) begin
         b1_now[p]    = PLR[6*p+5];
         b1_held[p]   = plr_q[6*p+5];
         unused_spare = unused_spare ^ plr_q[6*p+4];
      end
   end

   // Free-running NMI timer; commands never touch it.
   always_ff @(posedge CL or posedge RESET) begin
      if (RESET)                  nmi_cnt_q <= '0;
      else if (nmi_cnt_q == CNT_MAX) nmi_cnt_q <= '0;
      else                        nmi_cnt_q <= nmi_cnt_q + 1'b1;
   end

   always_ff @(posedge CL or posedge RESET) begin
      if (RESET) begin
         command_q   <= 8'h00;
         mode_sw_q   <= 1'b0;
         nmi_en_q    <= 1'b0;
         credit_at_q <= 1'b0;
         stg_coins_q <= '0;
         stg_cred_q  <= '0;
         cfg_coins_q <= '0;
         cfg_cred_q  <= '0;
      end else begin
         if (cmd_wr) begin
            command_q <= DI;
            nmi_en_q  <= (DI != 8'h10);
            if (DI == 8'hA1)                     mode_sw_q <= 1'b1;
            else if (DI == 8'hC1 || DI == 8'hE1) mode_sw_q <= 1'b0;
         end
         if (data_wr && command_q == 8'hC1) begin
            case (AD[3:0])
               4'd2: stg_coins_q[0] <= DI[3:0];
               4'd3: stg_cred_q[0]  <= DI[3:0];
               4'd4: stg_coins_q[1] <= DI[3:0];
               4'd5: stg_cred_q[1]  <= DI[3:0];
               4'd8: begin
                  cfg_coins_q <= stg_coins_q;
                  cfg_cred_q  <= stg_cred_q;
                  credit_at_q <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   // Credit update applied at a frame tick; coin1 then coin2, clamp, then starts lowest first.
   always_comb begin
      credits_d  = credits_q;
      coin_cnt_d = coin_cnt_q;
      coin_ok    = 2'b00;
      if (credit_at_q) begin
         for (int c = 0; c < 2; c++) begin
            if (c == 0 && cfg_coins_q[0] == 4'd0) begin
               credits_d = 8'd2;  // free play
            end else if (coin_edge_now[c] && credits_d < MAX_C) begin
               coin_ok[c] = 1'b1;
               if (({1'b0, coin_cnt_q[c]} + 5'd1) >= {1'b0, cfg_coins_q[c]}) begin
                  credits_d     = sat_add(credits_d, cfg_cred_q[c]);
                  coin_cnt_d[c] = 4'd0;
               end else begin
                  coin_cnt_d[c] = coin_cnt_q[c] + 4'd1;
               end
            end
         end
         if (credits_d > MAX_C) credits_d = MAX_C;
         for (int n = 0; n < NP; n++) begin
            if (start_dly[n] && credits_d >= 8'(n + 1)) credits_d = credits_d - 8'(n + 1);
         end
      end
   end

   always_ff @(posedge CL or posedge RESET) begin
      if (RESET) begin
         vblk_q       <= 1'b0;
         svc_q        <= 1'b0;
         coin_held_q  <= '0;
         coin_edge_q  <= '0;
         start_held_q <= '0;
         start_pipe_q <= '0;
         plr_q        <= '0;
         b1_edge_q    <= '0;
         credits_q    <= 8'd0;
         coin_cnt_q   <= '0;
      end else begin
         vblk_q <= VBLK;
         if (tick) begin
            svc_q           <= SYS[7];
            coin_held_q     <= {SYS[5], SYS[4]};
            coin_edge_q     <= coin_edge_now;
            start_held_q    <= START;
            start_pipe_q[0] <= start_edge_now;
            for (int i = 1; i < int'(START_DELAY); i++) start_pipe_q[i] <= start_pipe_q[i-1];
            plr_q           <= PLR;
            b1_edge_q       <= b1_now & ~b1_held;
            credits_q       <= credits_d;
            coin_cnt_q      <= coin_cnt_d;
         end
      end
   end

`ifdef CUSIO_COIN_COUNTER_EN
   logic [1:0] coincnt_q;
   always_ff @(posedge CL or posedge RESET) begin
      if (RESET)     coincnt_q <= 2'b00;
      else if (tick) coincnt_q <= coin_ok;
   end
   assign COINCNT = coincnt_q;
`else
   logic unused_coin_ok;
   assign unused_coin_ok = ^coin_ok;
`endif

   logic unused_sys;
   assign unused_sys = ^{SYS[6], SYS[3:0], unused_spare};

   assign idx_in = {1'b0, AD[3:0]} <= NP5;

   always_comb begin
      rd_pl   = '0;
      rd_edge = 1'b0;
      for (int p = 0; p < NP; p++) begin
         if (AD[3:0] == 4'(p + 1)) begin
            rd_pl   = plr_q[6*p +: 6];
            rd_edge = b1_edge_q[p];
         end
      end
      DO = 8'hFF;
      if (AD[4]) begin
         DO = 8'h00;
      end else begin
         case (command_q)
            8'h71: begin
               if (AD[3:0] == 4'd0) begin
                  DO = mode_sw_q ? ~{svc_q, 1'b0, start_dly4[1], start_dly4[0], 2'b00,
                                     coin_edge_q[1], coin_edge_q[0]}
                                 : to_bcd(credits_q);
               end else if (idx_in) begin
                  DO = mode_sw_q ? ~{2'b00, rd_pl[5], rd_edge, rd_pl[3:0]}
                                 : {2'b11, ~rd_pl[5], ~rd_edge, dir_code(rd_pl[3:0])};
               end
            end
            8'hB1: if (idx_in) DO = 8'h00;
            8'hD2: begin
               if (AD[3:0] == 4'd0)      DO = DSW0;
               else if (AD[3:0] == 4'd1) DO = DSW1;
            end
            default: ;
         endcase
      end
   end

endmodule
